seven_seg_to_bin: RTL

SEVEN_SEG_TO_BIN -- requirements
Module: seven_seg_to_bin

---
 rtl/seven_seg_to_bin_pkg.sv | 25 ++
 rtl/seven_seg_to_bin_seg_to_digit.sv | 33 +++
 rtl/seven_seg_to_bin.sv | 123 ++++++++++++
 3 files changed

// File: rtl/seven_seg_to_bin_pkg.sv
// Shared constants and types for the seven-segment pair decoder.
// Segment patterns are active-low, bit 0 = top ... bit 6 = middle.
package seven_seg_to_bin_pkg;

    localparam int SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1011000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        S_TEN,
        S_ONE,
        S_OUT
    } state_e;

endpackage

// File: rtl/seven_seg_to_bin_seg_to_digit.sv
// Combinational decode of one active-low segment pattern.
// Blank is reported as legal; callers decide what blank means.
module seg_to_digit
    import seven_seg_to_bin_pkg::*;
(
    input  logic [SEG_W-1:0] i_seg,
    output logic [3:0]       o_digit,
    output logic             o_blank,
    output logic             o_legal
);

    // Map pattern to digit value, flag blank and unknown patterns.
    always_comb begin
        o_digit = 4'd0;
        o_blank = 1'b0;
        o_legal = 1'b1;
        case (i_seg)
            SEG_0:     o_digit = 4'd0;
            SEG_1:     o_digit = 4'd1;
            SEG_2:     o_digit = 4'd2;
            SEG_3:     o_digit = 4'd3;
            SEG_4:     o_digit = 4'd4;
            SEG_5:     o_digit = 4'd5;
            SEG_6:     o_digit = 4'd6;
            SEG_7:     o_digit = 4'd7;
            SEG_8:     o_digit = 4'd8;
            SEG_9:     o_digit = 4'd9;
            SEG_BLANK: o_blank = 1'b1;
            default:   o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_seg_to_bin.sv
// Collects a tens/ones digit pair and emits a saturated binary value.
// Result is held until the consumer takes it; no bypass from output.
module seven_seg_to_bin
    import seven_seg_to_bin_pkg::*;
#(
    parameter int MAX_VAL = 31,
    parameter int VAL_W   = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [SEG_W-1:0] i_seg,
    input  logic             i_seg_valid,
    output logic             o_seg_ready,
    output logic [VAL_W-1:0] o_val,
    output logic             o_val_valid,
    input  logic             i_val_ready,
    output logic             o_err,
    output logic             o_ovf
);

    state_e           state_q, state_d;
    logic [3:0]       tens_q, tens_d;
    logic             err_q, err_d;
    logic [VAL_W-1:0] val_q, val_d;
    logic             vv_q, vv_d;
    logic             oerr_q, oerr_d;
    logic             ovf_q, ovf_d;

    logic [3:0]       dig;
    logic             blank;
    logic             legal;
    logic             seg_hs;
    logic [6:0]       sum;
    logic             pair_err;

    seg_to_digit u_dec (
        .i_seg   (i_seg),
        .o_digit (dig),
        .o_blank (blank),
        .o_legal (legal)
    );

    assign o_seg_ready = (state_q != S_OUT);
    assign seg_hs      = i_seg_valid && o_seg_ready;
    assign o_val       = val_q;
    assign o_val_valid = vv_q;
    assign o_err       = oerr_q;
    assign o_ovf       = ovf_q;

    // Full-width sum so saturation sees the true value.
    assign sum = ({3'b000, tens_q} * 7'd10) + {3'b000, dig};
    assign pair_err = err_q || !legal || blank;

    // Next-state and next-result logic for the pair FSM.
    always_comb begin
        state_d = state_q;
        tens_d  = tens_q;
        err_d   = err_q;
        val_d   = val_q;
        vv_d    = vv_q;
        oerr_d  = oerr_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_TEN: begin
                if (seg_hs) begin
                    tens_d  = dig;
                    err_d   = !legal;
                    state_d = S_ONE;
                end
            end
            S_ONE: begin
                if (seg_hs) begin
                    state_d = S_OUT;
                    vv_d    = 1'b1;
                    err_d   = pair_err;
                    if (pair_err) begin
                        oerr_d = 1'b1;
                        ovf_d  = 1'b0;
                        val_d  = '0;
                    end else if (int'(sum) > MAX_VAL) begin
                        oerr_d = 1'b0;
                        ovf_d  = 1'b1;
                        val_d  = VAL_W'(MAX_VAL);
                    end else begin
                        oerr_d = 1'b0;
                        ovf_d  = 1'b0;
                        val_d  = VAL_W'(sum);
                    end
                end
            end
            S_OUT: begin
                if (i_val_ready) begin
                    state_d = S_TEN;
                    vv_d    = 1'b0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_TEN;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_TEN;
            tens_q  <= 4'd0;
            err_q   <= 1'b0;
            val_q   <= '0;
            vv_q    <= 1'b0;
            oerr_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tens_q  <= tens_d;
            err_q   <= err_d;
            val_q   <= val_d;
            vv_q    <= vv_d;
            oerr_q  <= oerr_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule
